ws2812_frame_ctrl: RTL and testbench

Frame sequencer directly upstream of the single-LED RZ encoder in the WS2812 chain.
- Reads NUM_PIXELS colour words from a synchronous pixel buffer.
- Reorders each word from RGB to GRB, presents it to the encoder and advances on the encoder's per-word done pulse.
- After the last pixel, holds the line idle (tx_en low) for the WS2812 latch/reset gap (>50 us), then reports frame completion.

---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_gap_timer.sv | 40 ++++
 rtl/ws2812_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 timing constants, state encoding and colour reorder helper
package ws2812_pkg;

    localparam int CLK_HZ               = 50_000_000;
    localparam int BIT_CYCLES           = 63;
    localparam int T0H_CYCLES           = 15;
    localparam int T1H_CYCLES           = 45;
    localparam int RESET_CYCLES_DEFAULT = 3000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        LOAD0  = 3'd2,
        SEND   = 3'd3,
        LATCH  = 3'd4,
        DONE   = 3'd5
    } ws2812_state_e;

    // Buffer words are {R,G,B}; the LEDs shift in G first, then R, then B.
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_gap_timer.sv
// rtl/ws2812_gap_timer.sv - loadable down-counter that flags the end of the latch gap
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        loads load_val and starts counting down
//   load_val    cycles to run minus one
//   done        high for the single cycle in which the count reaches zero
module ws2812_gap_timer #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic             run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Loading N-1 gives a done in the Nth cycle after the load edge.
    assign done = run && (cnt == '0);

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - frame sequencer feeding GRB pixel words to a WS2812 bit encoder
//
// Ports:
//   clk, rst_n   50 MHz clock, asynchronous active-low reset
//   start        one-cycle request to send a frame (ignored unless idle)
//   pix_rd       pixel buffer read strobe
//   pix_addr     pixel buffer address
//   pix_data     buffer word {R,G,B}, valid the cycle after pix_rd
//   rgb          current word for the encoder, {G,R,B}
//   tx_en        encoder enable
//   tx_done      encoder pulse marking the end of the current word
//   busy         high from accepted start until frame_done
//   frame_done   one-cycle pulse at the end of the latch gap
//
// Build option: WS2812_AUTO_REFRESH_EN makes frames repeat back to back
// after the first start, re-reading the buffer each frame.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_PIXELS   = 64,
    parameter int ADDR_W       = 6,
    parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_data,
    output logic [23:0]       rgb,
    output logic              tx_en,
    input  logic              tx_done,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_FETCH0 = FETCH0;
    localparam logic [2:0] S_LOAD0  = LOAD0;
    localparam logic [2:0] S_SEND   = SEND;
    localparam logic [2:0] S_LATCH  = LATCH;
    localparam logic [2:0] S_DONE   = DONE;

    localparam int GAP_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIXELS - 1);
    // Two extra bits so n+2 and NUM_PIXELS compare without overflow even
    // when the buffer is completely full.
    localparam logic [ADDR_W+1:0] NUM_PIX_W = (ADDR_W + 2)'(NUM_PIXELS);

    logic [2:0]        state;
    logic [23:0]       shadow;
    logic [ADDR_W-1:0] pix_n;
    logic              cap_pend;
    logic [ADDR_W+1:0] n_plus2;
    logic              last_word;
    logic              gap_load;
    logic              gap_done;

    assign n_plus2   = {2'b00, pix_n} + (ADDR_W + 2)'(2);
    assign last_word = (pix_n == LAST_PIX);
    assign gap_load  = (state == S_SEND) && tx_done && last_word;

    ws2812_gap_timer #(
        .CNT_W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GAP_W'(RESET_CYCLES - 1)),
        .done     (gap_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pix_rd     <= 1'b0;
            pix_addr   <= '0;
            rgb        <= '0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shadow     <= '0;
            pix_n      <= '0;
            cap_pend   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        pix_rd   <= 1'b1;
                        pix_addr <= '0;
                        state    <= S_FETCH0;
                    end
                end
                S_FETCH0: begin
                    pix_rd <= 1'b0;
                    state  <= S_LOAD0;
                end
                S_LOAD0: begin
                    rgb      <= rgb_to_grb(pix_data);
                    tx_en    <= 1'b1;
                    pix_n    <= '0;
                    cap_pend <= 1'b0;
                    if (NUM_PIXELS > 1) begin
                        pix_rd   <= 1'b1;
                        pix_addr <= ADDR_W'(1);
                    end
                    state <= S_SEND;
                end
                S_SEND: begin
                    // Prefetch: strobe drops after one cycle, data is
                    // captured into the shadow register the cycle after.
                    if (pix_rd) begin
                        pix_rd   <= 1'b0;
                        cap_pend <= 1'b1;
                    end
                    if (cap_pend) begin
                        shadow   <= rgb_to_grb(pix_data);
                        cap_pend <= 1'b0;
                    end
                    if (tx_done) begin
                        if (!last_word) begin
                            rgb   <= shadow;
                            pix_n <= pix_n + 1'b1;
                            if (n_plus2 < NUM_PIX_W) begin
                                pix_rd   <= 1'b1;
                                pix_addr <= n_plus2[ADDR_W-1:0];
                            end
                        end else begin
                            tx_en <= 1'b0;
                            state <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (gap_done) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef WS2812_AUTO_REFRESH_EN
                    // Re-enter the fetch path with the address-0 read
                    // already issued, exactly as a start from IDLE does.
                    pix_rd   <= 1'b1;
                    pix_addr <= '0;
                    state    <= S_FETCH0;
`else
                    busy  <= 1'b0;
                    state <= S_IDLE;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - randomized self-checking bench for ws2812_frame_ctrl
module tb_ws2812_frame_ctrl;

    localparam int NP_A = 3;
    localparam int AW_A = 2;
    localparam int RC_A = 3000;
    localparam int RC_B = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start_a = 1'b0;
    logic            tx_done_a = 1'b0;
    logic            pix_rd_a;
    logic [AW_A-1:0] pix_addr_a;
    logic [23:0]     pix_data_a = '0;
    logic [23:0]     rgb_a;
    logic            tx_en_a, busy_a, frame_done_a;
    logic [23:0]     mem_a [0:3];
    logic [23:0]     snap_a [0:3];

    logic            start_b = 1'b0;
    logic            tx_done_b = 1'b0;
    logic            pix_rd_b;
    logic [0:0]      pix_addr_b;
    logic [23:0]     pix_data_b = '0;
    logic [23:0]     rgb_b;
    logic            tx_en_b, busy_b, frame_done_b;
    logic [23:0]     mem_b = '0;

    ws2812_frame_ctrl #(.NUM_PIXELS(NP_A), .ADDR_W(AW_A), .RESET_CYCLES(RC_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pix_rd(pix_rd_a),
        .pix_addr(pix_addr_a), .pix_data(pix_data_a), .rgb(rgb_a), .tx_en(tx_en_a),
        .tx_done(tx_done_a), .busy(busy_a), .frame_done(frame_done_a)
    );

    ws2812_frame_ctrl #(.NUM_PIXELS(1), .ADDR_W(1), .RESET_CYCLES(RC_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pix_rd(pix_rd_b),
        .pix_addr(pix_addr_b), .pix_data(pix_data_b), .rgb(rgb_b), .tx_en(tx_en_b),
        .tx_done(tx_done_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    // Synchronous pixel buffers: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (pix_rd_a) pix_data_a <= mem_a[pix_addr_a];
        if (pix_rd_b) pix_data_b <= mem_b;
    end

    int rd_q_a[$];
    int fd_cnt_a = 0;
    int rd_cnt_b = 0;

    always @(negedge clk) begin
        if (pix_rd_a) rd_q_a.push_back(int'(pix_addr_a));
        if (frame_done_a) fd_cnt_a++;
        if (pix_rd_b) rd_cnt_b++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference reorder: split into channels and re-pack green first.
    function automatic logic [23:0] grb_of(input logic [23:0] c);
        int r, g, b;
        r = (int'(c) >> 16) & 255;
        g = (int'(c) >> 8) & 255;
        b = int'(c) & 255;
        return 24'((g << 16) | (r << 8) | b);
    endfunction

    task automatic fill_random_a();
        for (int i = 0; i < 4; i++) mem_a[i] = 24'($urandom);
    endtask

    task automatic take_snapshot_a();
        for (int i = 0; i < 4; i++) snap_a[i] = mem_a[i];
    endtask

    task automatic check_idle_outputs_a(input string tag);
        check_eq({tag, "_pix_rd"}, pix_rd_a, 0);
        check_eq({tag, "_pix_addr"}, pix_addr_a, 0);
        check_eq({tag, "_rgb"}, rgb_a, 0);
        check_eq({tag, "_tx_en"}, tx_en_a, 0);
        check_eq({tag, "_busy"}, busy_a, 0);
        check_eq({tag, "_frame_done"}, frame_done_a, 0);
    endtask

    task automatic wait_tx_en_a(input int limit, output int cyc);
        cyc = 0;
        while (!tx_en_a && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic kick_a();
        int cyc;
        rd_q_a.delete();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_tx_en_a(20, cyc);
        check_eq("start_to_tx_en", cyc + 1, 3);
    endtask

    // Walk the words of the frame; abort_at stops with that word on the line.
    task automatic send_words_a(input int abort_at, input bit mid_start);
        int d;
        for (int i = 0; i < NP_A; i++) begin
            check_eq($sformatf("rgb_word%0d", i), rgb_a, grb_of(snap_a[i]));
            check_eq($sformatf("tx_en_word%0d", i), tx_en_a, 1);
            if (i == abort_at) return;
            d = $urandom_range(6, 30);
            if (mid_start && i == 1) begin
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                d = d - 1;
            end
            repeat (d) @(negedge clk);
            check_eq($sformatf("rgb_hold%0d", i), rgb_a, grb_of(snap_a[i]));
            tx_done_a = 1'b1;
            @(negedge clk);
            tx_done_a = 1'b0;
        end
        check_eq("tx_en_after_last", tx_en_a, 0);
        check_eq("busy_in_gap", busy_a, 1);
    endtask

    task automatic latch_a(input bit start_on_done);
        int gap = 0;
        int high_seen = 0;
        while (!frame_done_a && gap < RC_A + 50) begin
            if (tx_en_a) high_seen++;
            @(negedge clk);
            gap++;
        end
        check_eq("gap_len", gap, RC_A);
        check_eq("tx_en_in_gap", high_seen, 0);
        check_eq("busy_at_done", busy_a, 1);
        if (start_on_done) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("frame_done_width", frame_done_a, 0);
`ifdef WS2812_AUTO_REFRESH_EN
        check_eq("busy_after_done_auto", busy_a, 1);
`else
        check_eq("busy_after_done", busy_a, 0);
`endif
    endtask

    task automatic check_addrs_a(input string tag);
        check_eq({tag, "_nreads"}, rd_q_a.size(), NP_A);
        for (int i = 0; i < NP_A && i < rd_q_a.size(); i++)
            check_eq($sformatf("%s_addr%0d", tag, i), rd_q_a[i], i);
    endtask

    task automatic run_b();
        int cyc = 0;
        int gap = 0;
        mem_b = 24'($urandom);
        rd_cnt_b = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        while (!tx_en_b && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("b_start_to_tx_en", cyc + 1, 3);
        check_eq("b_rgb", rgb_b, grb_of(mem_b));
        repeat (8) @(negedge clk);
        check_eq("b_single_read", rd_cnt_b, 1);
        tx_done_b = 1'b1;
        @(negedge clk);
        tx_done_b = 1'b0;
        check_eq("b_tx_en_after_first_done", tx_en_b, 0);
        while (!frame_done_b && gap < RC_B + 50) begin
            @(negedge clk);
            gap++;
        end
        check_eq("b_gap_len", gap, RC_B);
        check_eq("b_reads_per_frame", rd_cnt_b, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem_a[i] = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs_a("reset");
        check_eq("reset_b_busy", busy_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef WS2812_AUTO_REFRESH_EN
        mem_a[0] = 24'hFF0000; mem_a[1] = 24'h00FF00; mem_a[2] = 24'h0000FF;
        take_snapshot_a();
        fd_cnt_a = 0;
        kick_a();
        mem_a[0] = 24'h123456;
        send_words_a(-1, 1'b0);
        latch_a(1'b0);
        begin
            int cyc;
            take_snapshot_a();
            wait_tx_en_a(20, cyc);
            check_eq("auto_restart_lat", cyc, 2);
            check_eq("auto_frame2_rgb0", rgb_a, 24'h341256);
            send_words_a(-1, 1'b0);
            latch_a(1'b0);
        end
        check_eq("auto_frame_done_count", fd_cnt_a, 2);
        check_eq("auto_busy_held", busy_a, 1);
`else
        // Directed primary-colour frame, plus start coincident with frame_done.
        mem_a[0] = 24'hFF0000; mem_a[1] = 24'h00FF00; mem_a[2] = 24'h0000FF;
        take_snapshot_a();
        fd_cnt_a = 0;
        kick_a();
        check_eq("primary_rgb0", rgb_a, 24'h00FF00);
        send_words_a(-1, 1'b0);
        latch_a(1'b1);
        repeat (5) @(negedge clk);
        check_eq("start_on_done_ignored", busy_a, 0);
        check_addrs_a("primary");
        check_eq("primary_frame_done_count", fd_cnt_a, 1);

        // Start pulsed mid-frame must not restart or queue a frame.
        fill_random_a();
        take_snapshot_a();
        fd_cnt_a = 0;
        kick_a();
        send_words_a(-1, 1'b1);
        latch_a(1'b0);
        repeat (5) @(negedge clk);
        check_addrs_a("midstart");
        check_eq("midstart_frame_done_count", fd_cnt_a, 1);
        check_eq("midstart_idle", busy_a, 0);

        // Random frames with random encoder pacing.
        for (int f = 0; f < 3; f++) begin
            fill_random_a();
            take_snapshot_a();
            kick_a();
            send_words_a(-1, 1'b0);
            latch_a(1'b0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            check_addrs_a($sformatf("rand%0d", f));
        end

        // Reset while pixel 2 is on the line, then a clean frame from address 0.
        fill_random_a();
        take_snapshot_a();
        kick_a();
        send_words_a(2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_tx_en", tx_en_a, 0);
        check_eq("rst_rgb", rgb_a, 0);
        check_eq("rst_busy", busy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs_a("post_reset");
        fill_random_a();
        take_snapshot_a();
        kick_a();
        send_words_a(-1, 1'b0);
        latch_a(1'b0);
        check_addrs_a("after_reset");
`endif

        run_b();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
